// File: rtl/if_stage_sramlike.sv
// if_stage_sramlike: IF stage on an SRAM-like instruction port; `IF_ADEF_CHECK_EN traps misaligned fetch pcs
module if_stage_sramlike #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_allow,
    input  logic [32:0] branch_bus,
    output logic        IF_to_ID_valid,
    output logic [63:0] IF_to_ID_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        IF_adef
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] r_br_target;
    logic        r_discard;
    logic        r_br_pending;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_redirect;
    logic        w_adef_stall;

    assign w_br_taken  = branch_bus[32];
    assign w_br_target = branch_bus[31:0];
    // a branch arriving this cycle overrides one remembered while waiting for addr_ok
    assign w_redirect  = w_br_taken ? w_br_target : r_br_target;

`ifdef IF_ADEF_CHECK_EN
    logic r_adef;
    assign w_adef_stall = r_pc[1:0] != 2'b00;
    assign IF_adef      = r_adef && r_state == S_HOLD && IF_to_ID_valid;
    always_ff @(posedge clk) begin
        if (reset)
            r_adef <= 1'b0;
        else if (r_state == S_REQ)
            r_adef <= w_adef_stall;
    end
`else
    assign w_adef_stall = 1'b0;
    assign IF_adef      = 1'b0;
`endif

    assign inst_sram_req   = ~reset && r_state == S_REQ && ~w_adef_stall;
    assign inst_sram_addr  = reset ? 32'h0 : r_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign IF_to_ID_valid  = ~reset && ~w_br_taken &&
                             (r_state == S_HOLD || (r_state == S_WAIT && inst_sram_data_ok && ~r_discard));
    assign IF_to_ID_bus    = reset ? 64'h0 :
                             {r_fetch_pc, r_state == S_HOLD ? r_inst_buf : inst_sram_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 32'h0;
            r_inst_buf   <= 32'h0;
            r_br_target  <= 32'h0;
            r_discard    <= 1'b0;
            r_br_pending <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_adef_stall) begin
                        if (w_br_taken || r_br_pending) begin
                            r_pc         <= w_redirect;
                            r_br_pending <= 1'b0;
                        end else begin
                            r_state    <= S_HOLD;
                            r_fetch_pc <= r_pc;
                            r_inst_buf <= 32'h0;
                        end
                    end else if (inst_sram_addr_ok) begin
                        r_fetch_pc <= r_pc;
                        r_state    <= S_WAIT;
                        if (w_br_taken || r_br_pending) begin
                            r_discard    <= 1'b1;
                            r_br_pending <= 1'b0;
                            r_pc         <= w_redirect;
                        end else begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end else if (w_br_taken) begin
                        r_br_pending <= 1'b1;
                        r_br_target  <= w_br_target;
                    end
                end
                S_WAIT: begin
                    if (w_br_taken)
                        r_pc <= w_br_target;
                    if (inst_sram_data_ok) begin
                        r_discard  <= 1'b0;
                        r_inst_buf <= inst_sram_rdata;
                        r_state    <= (~r_discard && ~w_br_taken && ~ID_allow) ? S_HOLD : S_REQ;
                    end else if (w_br_taken) begin
                        r_discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_br_taken)
                        r_pc <= w_br_target;
                    if (w_br_taken || ID_allow)
                        r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage_sramlike.sv
// tb_if_stage_sramlike: randomized SRAM-like responder with a pc-stream scoreboard for if_stage_sramlike
module tb_if_stage_sramlike;
    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ID_allow = 1'b0;
    logic [32:0] branch_bus = 33'h0;
    logic        IF_to_ID_valid;
    logic [63:0] IF_to_ID_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic        IF_adef;

    if_stage_sramlike dut (
        .clk(clk), .reset(reset), .ID_allow(ID_allow), .branch_bus(branch_bus),
        .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_bus(IF_to_ID_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .IF_adef(IF_adef)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h02800421;
    endfunction

    function automatic bit is_adef(input logic [31:0] a);
`ifdef IF_ADEF_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // test controls written by the main sequence
    bit          rst_req = 1, fast = 1, allow_rnd = 0, block_allow = 0, tp = 0, force_br = 0;
    int          br_rate = 0, hold_ok = 0;
    logic [31:0] force_tgt;

    // scoreboard: next pc the stage must hand to ID
    logic [31:0] exp_q[$];
    int          cyc = 0, last_cyc = 0, delivered = 0, adef_seen = 0;

    // SRAM responder and protocol checks
    logic [31:0] out_q[$];
    logic [31:0] acc_addr, prev_addr, tgt;
    bit          acc = 0, resp = 0, stray = 0, prev_wait = 0, first_req = 0;
    int          cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (resp && out_q.size() != 0) begin
                void'(out_q.pop_front());
                if (out_q.size() == 0) stray = 0;
            end
            if (acc) begin
                out_q.push_back(acc_addr);
                cnt = fast ? 0 : $urandom_range(0, 3);
            end else if (cnt > 0) cnt--;
            reset = rst_req;
            if (reset) begin
                exp_q.delete();
                exp_q.push_back(RST_PC);
                if (out_q.size() != 0) stray = 1;
                first_req = 1;
                last_cyc = 0;
            end
            inst_sram_data_ok = out_q.size() != 0 && cnt == 0;
            inst_sram_rdata   = inst_sram_data_ok ? mem(out_q[0]) : $urandom();
            if (reset || stray) inst_sram_addr_ok = 1'b0;
            else if (inst_sram_req && hold_ok > 0) begin
                inst_sram_addr_ok = 1'b0;
                hold_ok--;
            end else inst_sram_addr_ok = fast ? 1'b1 : ($urandom_range(0, 2) == 0);
            ID_allow = block_allow ? 1'b0 : allow_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            branch_bus = 33'h0;
            if (!reset && (force_br || (br_rate > 0 && $urandom_range(1, br_rate) == 1))) begin
                tgt = force_br ? force_tgt : RST_PC | ($urandom_range(0, 1023) << 2);
`ifdef IF_ADEF_CHECK_EN
                if (!force_br && $urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
                force_br = 0;
                branch_bus = {1'b1, tgt};
                exp_q.delete();
                exp_q.push_back(tgt);
            end
            #6;
            if (prev_wait && !reset) begin
                chk("req_held", inst_sram_req, 1);
                chk("addr_stable", inst_sram_addr, prev_addr);
            end
            if (!reset && inst_sram_req) begin
                if (!stray) chk("one_outstanding", out_q.size(), 0);
                if (first_req) begin
                    chk("first_req_addr", inst_sram_addr, RST_PC);
                    first_req = 0;
                end
            end
            acc       = !reset && inst_sram_req && inst_sram_addr_ok;
            acc_addr  = inst_sram_addr;
            resp      = inst_sram_data_ok;
            prev_wait = !reset && inst_sram_req && !inst_sram_addr_ok;
            prev_addr = inst_sram_addr;
        end
    end

    // monitor: compare every presented instruction with the scoreboard head
    int          idle = 0;
    logic [31:0] e_pc;
    bit          e_ad;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) idle = 0;
            else begin
                if (IF_to_ID_valid) begin
                    e_pc = exp_q.size() != 0 ? exp_q[0] : 32'hdeadbeef;
                    e_ad = is_adef(e_pc);
                    chk("deliver_pc", IF_to_ID_bus[63:32], e_pc);
                    chk("deliver_inst", IF_to_ID_bus[31:0], e_ad ? 32'h0 : mem(e_pc));
                    chk("adef_flag", IF_adef, e_ad);
                    if (ID_allow) begin
                        if (tp && last_cyc != 0) chk("throughput", cyc - last_cyc, 2);
                        last_cyc = cyc;
                        delivered++;
                        if (e_ad) adef_seen++;
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        exp_q.push_back(e_ad ? e_pc : e_pc + 32'd4);
                        idle = 0;
                    end
                end
                if (!(IF_to_ID_valid && ID_allow)) idle++;
                if (idle > 300) begin
                    chk("liveness_idle_cycles", idle, 0);
                    idle = 0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", inst_sram_req, 0);
        chk("rst_valid", IF_to_ID_valid, 0);
        chk("rst_adef", IF_adef, 0);
        chk("rst_addr", inst_sram_addr, 0);
        chk("rst_size", inst_sram_size, 2'b10);
        chk("rst_wr", inst_sram_wr, 0);
        chk("rst_wstrb", inst_sram_wstrb, 0);
        chk("rst_wdata", inst_sram_wdata, 0);
        rst_req = 0;
        tp = 1;
        repeat (14) @(negedge clk);
        tp = 0;
        hold_ok = 3;
        repeat (12) @(negedge clk);
        block_allow = 1;
        repeat (8) @(negedge clk);
        block_allow = 0;
        repeat (6) @(negedge clk);
        force_tgt = 32'h1c000100;
        force_br = 1;
        repeat (10) @(negedge clk);
        hold_ok = 2;
        @(negedge clk);
        force_tgt = 32'h1c000040;
        force_br = 1;
        repeat (12) @(negedge clk);
`ifdef IF_ADEF_CHECK_EN
        force_tgt = 32'h1c000102;
        force_br = 1;
        repeat (10) @(negedge clk);
        chk("adef_seen", adef_seen > 0, 1);
        force_tgt = 32'h1c000200;
        force_br = 1;
        repeat (10) @(negedge clk);
`endif
        fast = 0;
        allow_rnd = 1;
        br_rate = 8;
        repeat (1500) @(negedge clk);
        rst_req = 1;
        repeat (2) @(negedge clk);
        rst_req = 0;
        repeat (1500) @(negedge clk);
        br_rate = 0;
        allow_rnd = 0;
        fast = 1;
        repeat (30) @(negedge clk);
        chk("enough_deliveries", delivered > 100, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
